mac_host_sequencer: RTL and testbench

// Host-side driver for the mac unit interface (MAC_INA/MAC_INB/MAC_CTRL out, MAC_OUT/IRQ_MAC in).

---
 rtl/mac_host_sequencer.sv | 136 +++++++++++++
 tb/tb_mac_host_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_host_sequencer.sv
// rtl/mac_host_sequencer.sv - host-side job sequencer for the mac unit with IRQ watchdog
module mac_host_sequencer #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  CTRL_IDLE      = 8'h80,
    parameter logic [7:0]  CTRL_LOAD      = 8'h8D,
    parameter logic [7:0]  CTRL_RUN       = 8'h8F,
    parameter int          CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_a,
    input  logic [31:0]       cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              rsp_timeout,
    output logic [31:0]       MAC_INA,
    output logic [31:0]       MAC_INB,
    output logic [7:0]        MAC_CTRL,
    input  logic [15:0]       MAC_OUT,
    input  logic              IRQ_MAC,
    output logic              spurious_irq,
    output logic [CNT_W-1:0]  job_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_t;

    state_t             r_state, w_state;
    logic [31:0]        r_ina, w_ina;
    logic [31:0]        r_inb, w_inb;
    logic [7:0]         r_ctrl, w_ctrl;
    logic               r_rsp_valid, w_rsp_valid;
    logic [15:0]        r_rsp_data, w_rsp_data;
    logic               r_rsp_timeout, w_rsp_timeout;
    logic               r_spurious, w_spurious;
    logic [CNT_W-1:0]   r_job_count, w_job_count;
    logic [TW-1:0]      r_timer, w_timer;
    logic               w_timer_expired;

    assign cmd_ready       = (r_state == ST_IDLE) & reset;
    assign w_timer_expired = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state       = r_state;
        w_ina         = r_ina;
        w_inb         = r_inb;
        w_ctrl        = r_ctrl;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_data    = r_rsp_data;
        w_rsp_timeout = r_rsp_timeout;
        w_job_count   = r_job_count;
        w_timer       = r_timer;
        // Any IRQ outside the RUN window is a protocol error worth remembering.
        w_spurious    = r_spurious | (IRQ_MAC & (r_state != ST_RUN));
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_ina   = cmd_a;
                    w_inb   = cmd_b;
                    w_ctrl  = CTRL_LOAD;
                    w_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ctrl  = CTRL_RUN;
                w_timer = '0;
                w_state = ST_RUN;
            end
            ST_RUN: begin
                w_timer = r_timer + TW'(1);
                // IRQ takes priority over a watchdog expiry landing on the same cycle.
                if (IRQ_MAC) begin
                    w_rsp_data    = MAC_OUT;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_ctrl        = CTRL_IDLE;
                    w_state       = ST_RESP;
                end else if (w_timer_expired) begin
                    w_rsp_data    = '0;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_ctrl        = CTRL_IDLE;
                    w_state       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_job_count = r_job_count + CNT_W'(1);
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_ina         <= '0;
            r_inb         <= '0;
            r_ctrl        <= CTRL_IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_spurious    <= 1'b0;
            r_job_count   <= '0;
            r_timer       <= '0;
        end else begin
            r_state       <= w_state;
            r_ina         <= w_ina;
            r_inb         <= w_inb;
            r_ctrl        <= w_ctrl;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_data    <= w_rsp_data;
            r_rsp_timeout <= w_rsp_timeout;
            r_spurious    <= w_spurious;
            r_job_count   <= w_job_count;
            r_timer       <= w_timer;
        end
    end

    assign MAC_INA      = r_ina;
    assign MAC_INB      = r_inb;
    assign MAC_CTRL     = r_ctrl;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_timeout  = r_rsp_timeout;
    assign spurious_irq = r_spurious;
    assign job_count    = r_job_count;

endmodule

// File: tb/tb_mac_host_sequencer.sv
// tb/tb_mac_host_sequencer.sv - directed self-checking bench for mac_host_sequencer
module tb_mac_host_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [31:0] MAC_INA;
    logic [31:0] MAC_INB;
    logic [7:0]  MAC_CTRL;
    logic [15:0] MAC_OUT;
    logic        IRQ_MAC;
    logic        spurious_irq;
    logic [15:0] job_count;

    int checks = 0;
    int errors = 0;

    mac_host_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .MAC_INA      (MAC_INA),
        .MAC_INB      (MAC_INB),
        .MAC_CTRL     (MAC_CTRL),
        .MAC_OUT      (MAC_OUT),
        .IRQ_MAC      (IRQ_MAC),
        .spurious_irq (spurious_irq),
        .job_count    (job_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a command and advance into the first RUN cycle.
    task automatic start_job(input logic [31:0] a, input logic [31:0] b);
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("load_ctrl", MAC_CTRL, 8'h8D);
        tick();
        check("run_ctrl", MAC_CTRL, 8'h8F);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hs_rsp_valid", rsp_valid, 1'b0);
        check("hs_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        MAC_OUT   = '0;
        IRQ_MAC   = 1'b0;

        // T1 reset
        tick();
        tick();
        check("rst_ctrl", MAC_CTRL, 8'h80);
        check("rst_ina", MAC_INA, 32'h0);
        check("rst_inb", MAC_INB, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_ready_low", cmd_ready, 1'b0);
        reset = 1'b1;
        #1;
        check("rel_cmd_ready", cmd_ready, 1'b1);
        tick();
        check("idle_ctrl", MAC_CTRL, 8'h80);
        check("idle_job_count", job_count, 16'd0);
        check("idle_spurious", spurious_irq, 1'b0);

        // T2 normal job, IRQ 5 cycles after CTRL_RUN
        start_job(32'h56CE_8235, 32'h56CE_D903);
        check("t2_ina", MAC_INA, 32'h56CE_8235);
        check("t2_inb", MAC_INB, 32'h56CE_D903);
        check("t2_cmd_ready_busy", cmd_ready, 1'b0);
        repeat (4) begin
            tick();
            check("t2_run_ctrl", MAC_CTRL, 8'h8F);
            check("t2_no_rsp", rsp_valid, 1'b0);
        end
        IRQ_MAC = 1'b1;
        MAC_OUT = 16'hBEEF;
        tick();
        IRQ_MAC = 1'b0;
        MAC_OUT = 16'h0;
        check("t2_rsp_valid", rsp_valid, 1'b1);
        check("t2_rsp_data", rsp_data, 16'hBEEF);
        check("t2_rsp_timeout", rsp_timeout, 1'b0);
        check("t2_ctrl_idle", MAC_CTRL, 8'h80);
        check("t2_ina_retained", MAC_INA, 32'h56CE_8235);
        handshake();
        check("t2_job_count", job_count, 16'd1);

        // T3 watchdog timeout after exactly 64 RUN cycles
        start_job(32'h1111_2222, 32'h3333_4444);
        repeat (63) tick();
        check("t3_not_yet", rsp_valid, 1'b0);
        check("t3_still_run", MAC_CTRL, 8'h8F);
        tick();
        check("t3_rsp_valid", rsp_valid, 1'b1);
        check("t3_timeout", rsp_timeout, 1'b1);
        check("t3_data_zero", rsp_data, 16'h0);
        check("t3_ctrl_idle", MAC_CTRL, 8'h80);
        handshake();
        check("t3_job_count", job_count, 16'd2);

        // T4 IRQ on the timeout cycle wins
        start_job(32'hAAAA_5555, 32'h5555_AAAA);
        repeat (63) tick();
        check("t4_not_yet", rsp_valid, 1'b0);
        IRQ_MAC = 1'b1;
        MAC_OUT = 16'h1234;
        tick();
        IRQ_MAC = 1'b0;
        MAC_OUT = 16'h0;
        check("t4_rsp_valid", rsp_valid, 1'b1);
        check("t4_timeout", rsp_timeout, 1'b0);
        check("t4_data", rsp_data, 16'h1234);
        handshake();
        check("t4_job_count", job_count, 16'd3);

        // T5 back-pressure on the response with a pending command
        start_job(32'hA5A5_0001, 32'hB5B5_0002);
        IRQ_MAC = 1'b1;
        MAC_OUT = 16'h5A5A;
        tick();
        IRQ_MAC = 1'b0;
        MAC_OUT = 16'h0;
        cmd_a     = 32'hC0DE_0003;
        cmd_b     = 32'hF00D_0004;
        cmd_valid = 1'b1;
        repeat (10) begin
            tick();
            check("t5_rsp_valid", rsp_valid, 1'b1);
            check("t5_rsp_data", rsp_data, 16'h5A5A);
            check("t5_rsp_timeout", rsp_timeout, 1'b0);
            check("t5_cmd_ready", cmd_ready, 1'b0);
            check("t5_ctrl", MAC_CTRL, 8'h80);
            check("t5_ina", MAC_INA, 32'hA5A5_0001);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t5_hs_valid", rsp_valid, 1'b0);
        check("t5_hs_cmd_ready", cmd_ready, 1'b1);
        check("t5_job_count", job_count, 16'd4);
        check("t5_no_load_yet", MAC_CTRL, 8'h80);
        tick();
        cmd_valid = 1'b0;
        check("t5_next_load", MAC_CTRL, 8'h8D);
        check("t5_next_ina", MAC_INA, 32'hC0DE_0003);
        check("t5_next_inb", MAC_INB, 32'hF00D_0004);
        tick();
        check("t5_next_run", MAC_CTRL, 8'h8F);
        IRQ_MAC = 1'b1;
        MAC_OUT = 16'h0F0F;
        tick();
        IRQ_MAC = 1'b0;
        MAC_OUT = 16'h0;
        check("t5_next_data", rsp_data, 16'h0F0F);
        handshake();
        check("t5_job_count2", job_count, 16'd5);

        // T6 spurious IRQ then reset mid-RUN
        check("t6_spurious_clear", spurious_irq, 1'b0);
        IRQ_MAC = 1'b1;
        tick();
        IRQ_MAC = 1'b0;
        check("t6_spurious_set", spurious_irq, 1'b1);
        check("t6_no_rsp", rsp_valid, 1'b0);
        repeat (3) tick();
        check("t6_spurious_sticky", spurious_irq, 1'b1);
        start_job(32'hDEAD_BEEF, 32'hCAFE_F00D);
        tick();
        reset = 1'b0;
        tick();
        check("t6_rst_ctrl", MAC_CTRL, 8'h80);
        check("t6_rst_ina", MAC_INA, 32'h0);
        check("t6_rst_inb", MAC_INB, 32'h0);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_rsp_data", rsp_data, 16'h0);
        check("t6_rst_timeout", rsp_timeout, 1'b0);
        check("t6_rst_spurious", spurious_irq, 1'b0);
        check("t6_rst_job_count", job_count, 16'd0);
        check("t6_rst_cmd_ready", cmd_ready, 1'b0);
        reset = 1'b1;
        repeat (5) begin
            tick();
            check("t6_post_no_rsp", rsp_valid, 1'b0);
        end
        check("t6_post_cmd_ready", cmd_ready, 1'b1);
        check("t6_post_ctrl", MAC_CTRL, 8'h80);
        check("t6_post_job_count", job_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
